cpu_control_unit: RTL and testbench

- Multi-cycle sequencer for the 8-bit CPU.
- Fetches one 8-bit instruction per cycle of the loop through a req/ack handshake, then decodes it.
- Drives the register-file read/write addresses, register write enable, PC increment enable and ALU opcode.
- Sits between instruction memory and the register file / ALU datapath. It is the only source of write_enable and pc_write_enable in the core.

---
 rtl/cpu_control_unit.sv | 167 ++++++++++++++++
 tb/tb_cpu_control_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
// Optional single-step gating between instructions: define SINGLE_STEP_EN.
`timescale 1ns/1ps

// state      | meaning
// S_FETCH    | imem_req high, waiting for imem_ack, timeout counter running
// S_DECODE   | IR valid, read addresses presented, classify opcode
// S_EXECUTE  | alu_op / rf_wsel_imm / rf_imm presented
// S_WB       | write strobe (opcodes 1-7) and PC strobe
// S_STEP_WAIT| waiting for step before next fetch (SINGLE_STEP_EN only)
// S_HALT     | halted, only reset_n leaves

module cpu_control_unit #(
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       imem_req,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic [1:0] rf_read_addr1,
   output logic [1:0] rf_read_addr2,
   output logic       rf_write_enable,
   output logic [1:0] rf_write_addr,
   output logic [7:0] rf_imm,
   output logic       rf_wsel_imm,
   output logic [2:0] alu_op,
   output logic       pc_write_enable,
   output logic       halted,
   output logic       illegal_op,
`ifdef SINGLE_STEP_EN
   input  logic       step,
   output logic       step_wait,
`endif
   output logic       fetch_error
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WB        = 3'd3,
      S_STEP_WAIT = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   localparam bit TO_EN = (FETCH_TIMEOUT > 0);
   localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

   state_t           state, state_nxt;
   logic [7:0]       ir;
   logic [CNT_W-1:0] wait_cnt;
   logic [3:0]       opcode;
   logic             op_writes;
   logic             op_illegal;
   logic             op_halt;
   logic             timeout_hit;
   logic             fetch_take;
   logic [2:0]       alu_dec;

   assign opcode     = ir[7:4];
   assign op_writes  = (opcode[3] == 1'b0) && (opcode != 4'h0);
   assign op_halt    = (opcode == 4'hF);
   assign op_illegal = opcode[3] && !op_halt;

   assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);
   assign fetch_take  = (state == S_FETCH) && imem_ack;

   // Read addresses follow IR, which only changes on an accepted fetch.
   assign rf_read_addr1 = ir[3:2];
   assign rf_read_addr2 = ir[1:0];

   assign halted = (state == S_HALT);

   // Request is held low while reset is asserted so every output reads 0.
   assign imem_req = (state == S_FETCH) && reset_n;

`ifdef SINGLE_STEP_EN
   assign step_wait = (state == S_STEP_WAIT);
`endif

   always_comb begin
      alu_dec = 3'd0;
      case (opcode)
         4'h1: alu_dec = 3'd0;
         4'h2: alu_dec = 3'd1;
         4'h3: alu_dec = 3'd2;
         4'h4: alu_dec = 3'd3;
         4'h5: alu_dec = 3'd4;
         4'h6: alu_dec = 3'd5;
         default: alu_dec = 3'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_FETCH;
         ir          <= 8'h00;
         wait_cnt    <= '0;
         illegal_op  <= 1'b0;
         fetch_error <= 1'b0;
      end else begin
         state <= state_nxt;
         if (fetch_take)
            ir <= imem_data;
         if (TO_EN && (state == S_FETCH) && !imem_ack)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if ((state == S_DECODE) && op_illegal)
            illegal_op <= 1'b1;
         if ((state == S_FETCH) && !imem_ack && timeout_hit)
            fetch_error <= 1'b1;
      end
   end

   always_comb begin
      state_nxt       = state;
      rf_write_enable = 1'b0;
      rf_write_addr   = 2'd0;
      rf_imm          = 8'h00;
      rf_wsel_imm     = 1'b0;
      alu_op          = 3'd0;
      pc_write_enable = 1'b0;
      case (state)
         S_FETCH: begin
            if (imem_ack)
               state_nxt = S_DECODE;
            else if (timeout_hit)
               state_nxt = S_HALT;
         end
         S_DECODE: begin
            // Illegal opcodes fall through as NOPs: no write, PC still advances.
            if (op_halt)
               state_nxt = S_HALT;
            else
               state_nxt = S_EXECUTE;
         end
         S_EXECUTE: begin
            alu_op      = alu_dec;
            rf_wsel_imm = (opcode == 4'h7);
            rf_imm      = (opcode == 4'h7) ? {6'b0, ir[1:0]} : 8'h00;
            state_nxt   = S_WB;
         end
         S_WB: begin
            rf_write_enable = op_writes;
            rf_write_addr   = op_writes ? ir[3:2] : 2'd0;
            pc_write_enable = 1'b1;
`ifdef SINGLE_STEP_EN
            state_nxt       = S_STEP_WAIT;
`else
            state_nxt       = S_FETCH;
`endif
         end
`ifdef SINGLE_STEP_EN
         S_STEP_WAIT: begin
            if (step)
               state_nxt = S_FETCH;
         end
`endif
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: driver pushes expected retire records,
// monitor pops one per PC strobe and compares write/ALU/immediate fields.
`timescale 1ns/1ps

module tb_cpu_control_unit;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       imem_req;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'h00;
   logic [1:0] rf_read_addr1, rf_read_addr2;
   logic       rf_write_enable;
   logic [1:0] rf_write_addr;
   logic [7:0] rf_imm;
   logic       rf_wsel_imm;
   logic [2:0] alu_op;
   logic       pc_write_enable;
   logic       halted, illegal_op, fetch_error;
`ifdef SINGLE_STEP_EN
   logic       step = 1'b1;
   logic       step_wait;
   localparam int PERIOD = 5;
`else
   localparam int PERIOD = 4;
`endif

   cpu_control_unit #(.FETCH_TIMEOUT(15)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .imem_req        (imem_req),
      .imem_ack        (imem_ack),
      .imem_data       (imem_data),
      .rf_read_addr1   (rf_read_addr1),
      .rf_read_addr2   (rf_read_addr2),
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_imm          (rf_imm),
      .rf_wsel_imm     (rf_wsel_imm),
      .alu_op          (alu_op),
      .pc_write_enable (pc_write_enable),
      .halted          (halted),
      .illegal_op      (illegal_op),
`ifdef SINGLE_STEP_EN
      .step            (step),
      .step_wait       (step_wait),
`endif
      .fetch_error     (fetch_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       we;
      logic [1:0] waddr;
      logic [2:0] alu;
      logic       wsel;
      logic [7:0] imm;
      logic [1:0] ra1;
      logic [1:0] ra2;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   int   pc_times[$];
   int   pc_count = 0;
   int   req_run = 0;
   int   last_req_run = 0;
   logic [2:0] prev_alu = '0;
   logic       prev_wsel = 1'b0;
   logic [7:0] prev_imm = '0;
   exp_t       mon_e;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic we, input logic [1:0] wa, input logic [2:0] alu,
                               input logic wsel, input logic [7:0] imm,
                               input logic [1:0] ra1, input logic [1:0] ra2);
      exp_t e;
      e.we = we; e.waddr = wa; e.alu = alu; e.wsel = wsel; e.imm = imm;
      e.ra1 = ra1; e.ra2 = ra2;
      return e;
   endfunction

   // Monitor: one retire record per PC strobe; ALU/immediate fields are taken
   // from the EXECUTE cycle, which is the cycle before the strobe.
   always @(negedge clk) begin
      if (reset_n) begin
         if (imem_req) req_run++;
         else if (req_run != 0) begin
            last_req_run = req_run;
            req_run = 0;
         end
         if (rf_write_enable && !pc_write_enable)
            check("we_outside_wb", rf_write_enable, 1'b0);
         if (pc_write_enable) begin
            pc_count++;
            pc_times.push_back(cyc);
            if (sb.size() == 0)
               check("unexpected_retire", pc_write_enable, 1'b0);
            else begin
               mon_e = sb.pop_front();
               check("wr_en",     rf_write_enable, mon_e.we);
               check("wr_addr",   rf_write_addr,   mon_e.waddr);
               check("alu_op",    prev_alu,        mon_e.alu);
               check("wsel_imm",  prev_wsel,       mon_e.wsel);
               check("imm",       prev_imm,        mon_e.imm);
               check("read_addr1", rf_read_addr1,  mon_e.ra1);
               check("read_addr2", rf_read_addr2,  mon_e.ra2);
            end
         end
      end else begin
         req_run = 0;
      end
      prev_alu  = alu_op;
      prev_wsel = rf_wsel_imm;
      prev_imm  = rf_imm;
   end

   // Called on a falling edge; waits for imem_req, then acks after 'delay' cycles.
   task automatic fetch(input logic [7:0] d, input int delay, input bit push, input exp_t e);
      int n = 0;
      while (!imem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("req_wait_timeout", imem_req, 1'b1);
      if (push) sb.push_back(e);
      repeat (delay) @(negedge clk);
      imem_data = d;
      imem_ack  = 1'b1;
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_data = 8'h00;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_pending", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int pc0;
      int bad;
      exp_t none;
      none = '0;

      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req",     imem_req, 1'b0);
      check("rst_halted",  halted, 1'b0);
      check("rst_illegal", illegal_op, 1'b0);
      check("rst_ferr",    fetch_error, 1'b0);
      check("rst_pc",      pc_write_enable, 1'b0);
      check("rst_we",      rf_write_enable, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      check("req_after_reset", imem_req, 1'b1);

      // Reset during DECODE of ADD R1,R2
      pc0 = pc_count;
      fetch(8'h16, 0, 1'b0, none);
      check("decode_ra1", rf_read_addr1, 2'd1);
      check("decode_ra2", rf_read_addr2, 2'd2);
      reset_n = 1'b0;
      #1;
      check("abort_ra1",  rf_read_addr1, 2'd0);
      check("abort_ra2",  rf_read_addr2, 2'd0);
      check("abort_req",  imem_req, 1'b0);
      check("abort_we",   rf_write_enable, 1'b0);
      check("abort_pc",   pc_write_enable, 1'b0);
      check("abort_alu",  alu_op, 3'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("abort_refetch_req", imem_req, 1'b1);
      check("abort_no_retire", pc_count, pc0);

      // LDI R1,3 / LDI R2,2 / ADD R1,R2 with immediate ack
      base = pc_times.size();
      fetch(8'h77, 0, 1'b1, mk(1'b1, 2'd1, 3'd0, 1'b1, 8'd3, 2'd1, 2'd3));
      fetch(8'h7A, 0, 1'b1, mk(1'b1, 2'd2, 3'd0, 1'b1, 8'd2, 2'd2, 2'd2));
      fetch(8'h16, 0, 1'b1, mk(1'b1, 2'd1, 3'd0, 1'b0, 8'd0, 2'd1, 2'd2));
      drain();
      check("stream_pc_count", pc_times.size() - base, 3);
      if (pc_times.size() >= base + 3) begin
         check("pc_gap_1", pc_times[base+1] - pc_times[base], PERIOD);
         check("pc_gap_2", pc_times[base+2] - pc_times[base+1], PERIOD);
      end

      // Remaining ALU ops, then NOP with ack delayed 5 cycles
      fetch(8'h2D, 0, 1'b1, mk(1'b1, 2'd3, 3'd1, 1'b0, 8'd0, 2'd3, 2'd1));
      fetch(8'h3B, 0, 1'b1, mk(1'b1, 2'd2, 3'd2, 1'b0, 8'd0, 2'd2, 2'd3));
      fetch(8'h44, 0, 1'b1, mk(1'b1, 2'd1, 3'd3, 1'b0, 8'd0, 2'd1, 2'd0));
      fetch(8'h5F, 0, 1'b1, mk(1'b1, 2'd3, 3'd4, 1'b0, 8'd0, 2'd3, 2'd3));
      fetch(8'h69, 0, 1'b1, mk(1'b1, 2'd2, 3'd5, 1'b0, 8'd0, 2'd2, 2'd1));
      fetch(8'h00, 5, 1'b1, mk(1'b0, 2'd0, 3'd0, 1'b0, 8'd0, 2'd0, 2'd0));
      drain();
      check("nop_req_cycles", last_req_run, 6);

      // Illegal opcode then a normal LDI R2,3
      check("illegal_before", illegal_op, 1'b0);
      pc0 = pc_count;
      fetch(8'hA5, 0, 1'b1, mk(1'b0, 2'd0, 3'd0, 1'b0, 8'd0, 2'd1, 2'd1));
      fetch(8'h7B, 0, 1'b1, mk(1'b1, 2'd2, 3'd0, 1'b1, 8'd3, 2'd2, 2'd3));
      drain();
      check("illegal_sticky", illegal_op, 1'b1);
      check("illegal_pc_count", pc_count - pc0, 2);

      // HALT
      pc0 = pc_count;
      fetch(8'hF0, 0, 1'b0, none);
      check("halt_not_yet", halted, 1'b0);
      @(negedge clk);
      check("halt_set", halted, 1'b1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req || !halted) bad++;
      end
      check("halt_idle_cycles", bad, 0);
      check("halt_no_pc", pc_count, pc0);
      reset_n = 1'b0;
      #1;
      check("halt_cleared", halted, 1'b0);
      check("illegal_cleared", illegal_op, 1'b0);

      // Fetch timeout with no ack
      @(negedge clk);
      reset_n = 1'b1;
      repeat (14) @(negedge clk);
      check("to_early_halt", halted, 1'b0);
      check("to_early_ferr", fetch_error, 1'b0);
      @(negedge clk);
      check("to_ferr", fetch_error, 1'b1);
      check("to_halted", halted, 1'b1);
      check("to_req_low", imem_req, 1'b0);

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
